// File: rtl/flag_ctrl_if.sv
// Flag controller bus: ALU/control-unit strobes in, registered flags and
// interrupt request out.
interface flag_ctrl_if;
  logic alu_c;
  logic alu_z;
  logic c_ld;
  logic z_ld;
  logic c_set;
  logic c_clr;
  logic shad_restore;
  logic i_set;
  logic i_clr;
  logic intr;
  logic intr_ack;
  logic c_flag;
  logic z_flag;
  logic i_flag;
  logic intr_pend;

  modport master (
    output alu_c, alu_z, c_ld, z_ld,
    output c_set, c_clr, shad_restore,
    output i_set, i_clr, intr, intr_ack,
    input  c_flag, z_flag, i_flag, intr_pend
  );

  modport slave (
    input  alu_c, alu_z, c_ld, z_ld,
    input  c_set, c_clr, shad_restore,
    input  i_set, i_clr, intr, intr_ack,
    output c_flag, z_flag, i_flag, intr_pend
  );
endinterface

// File: rtl/flag_ctrl.sv
// C/Z/I flag register with shadow copies and interrupt edge latch.
// Define INTR_SYNC_EN to put a two-flop synchronizer ahead of the detector.
module flag_ctrl (
  input  logic       clk,
  input  logic       reset,
  flag_ctrl_if.slave bus
);
  logic c_q;
  logic z_q;
  logic i_q;
  logic shad_c;
  logic shad_z;
  logic pend;
  logic intr_q;
  logic req;
  logic rise;

`ifdef INTR_SYNC_EN
  logic sync1;
  logic sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= bus.intr;
      sync2 <= sync1;
    end
  end

  assign req = sync2;
`else
  assign req = bus.intr;
`endif

  assign rise = req & ~intr_q;

  always_ff @(posedge clk) begin
    if (reset)
      c_q <= 1'b0;
    else if (bus.shad_restore)
      c_q <= shad_c;
    else if (bus.c_clr)
      c_q <= 1'b0;
    else if (bus.c_set)
      c_q <= 1'b1;
    else if (bus.c_ld)
      c_q <= bus.alu_c;
  end

  always_ff @(posedge clk) begin
    if (reset)
      z_q <= 1'b0;
    else if (bus.shad_restore)
      z_q <= shad_z;
    else if (bus.z_ld)
      z_q <= bus.alu_z;
  end

  // Shadow takes the pre-edge flags even when they update this edge
  always_ff @(posedge clk) begin
    if (reset) begin
      shad_c <= 1'b0;
      shad_z <= 1'b0;
    end else if (bus.intr_ack) begin
      shad_c <= c_q;
      shad_z <= z_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      i_q <= 1'b0;
    else if (bus.intr_ack)
      i_q <= 1'b0;
    else if (bus.i_clr)
      i_q <= 1'b0;
    else if (bus.i_set)
      i_q <= 1'b1;
  end

  // A new edge beats a simultaneous ack so the request is not lost
  always_ff @(posedge clk) begin
    if (reset) begin
      intr_q <= 1'b0;
      pend   <= 1'b0;
    end else begin
      intr_q <= req;
      if (rise)
        pend <= 1'b1;
      else if (bus.intr_ack)
        pend <= 1'b0;
    end
  end

  assign bus.c_flag    = c_q;
  assign bus.z_flag    = z_q;
  assign bus.i_flag    = i_q;
  assign bus.intr_pend = pend & i_q;
endmodule

// File: tb/tb_flag_ctrl.sv
// Bench for flag_ctrl: directed flag/interrupt scenarios, then random
// stimulus against a sample-history reference model.
module tb_flag_ctrl;
`ifdef INTR_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  localparam int D = LAT - 1;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;

  flag_ctrl_if bus ();

  flag_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic       mc, mz, mi, msc, msz, mpend;
  logic [3:0] hist;

  task automatic chk(input string tag, input logic got,
                     input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.alu_c = 0; bus.alu_z = 0;
    bus.c_ld = 0; bus.z_ld = 0;
    bus.c_set = 0; bus.c_clr = 0;
    bus.shad_restore = 0;
    bus.i_set = 0; bus.i_clr = 0;
    bus.intr_ack = 0;
    reset = 0;
  endtask

  // Reference: flags follow the priority rules; an interrupt event is a
  // 0->1 step in the intr samples, seen D edges late.
  task automatic model_edge();
    logic nc, nz, ni, rise;
    if (reset) begin
      {mc, mz, mi, msc, msz, mpend} = '0;
      hist = '0;
      return;
    end
    nc = mc;
    if (bus.shad_restore) nc = msc;
    else if (bus.c_clr) nc = 0;
    else if (bus.c_set) nc = 1;
    else if (bus.c_ld) nc = bus.alu_c;
    nz = mz;
    if (bus.shad_restore) nz = msz;
    else if (bus.z_ld) nz = bus.alu_z;
    ni = mi;
    if (bus.intr_ack || bus.i_clr) ni = 0;
    else if (bus.i_set) ni = 1;
    if (bus.intr_ack) begin
      msc = mc;
      msz = mz;
    end
    hist = {hist[2:0], bus.intr};
    rise = hist[D] & ~hist[D+1];
    mpend = rise | (mpend & ~bus.intr_ack);
    mc = nc; mz = nz; mi = ni;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("c_flag", bus.c_flag, mc);
    chk("z_flag", bus.z_flag, mz);
    chk("i_flag", bus.i_flag, mi);
    chk("intr_pend", bus.intr_pend, mpend & mi);
  endtask

  initial begin
    {mc, mz, mi, msc, msz, mpend} = '0;
    hist = '0;
    idle();
    bus.intr = 0;
    reset = 1;
    step();
    step();
    chk("rst_c", bus.c_flag, 0);
    chk("rst_pend", bus.intr_pend, 0);
    idle();

    // C priority
    bus.c_ld = 1; bus.alu_c = 1; step();
    chk("c_ld", bus.c_flag, 1);
    idle(); bus.c_set = 1; bus.c_clr = 1; step();
    chk("c_clr_wins", bus.c_flag, 0);
    idle(); bus.c_set = 1; bus.c_ld = 1; step();
    chk("c_set_wins", bus.c_flag, 1);

    // interrupt entry and exit
    idle(); bus.z_ld = 1; bus.i_set = 1; step();
    idle(); bus.intr = 1;
    for (int k = 0; k < LAT; k++) step();
    chk("entry_pend", bus.intr_pend, 1);
    bus.intr = 0; bus.intr_ack = 1; step();
    chk("ack_i", bus.i_flag, 0);
    chk("ack_pend", bus.intr_pend, 0);
    idle(); bus.z_ld = 1; bus.alu_z = 1; bus.c_clr = 1; step();
    chk("isr_c", bus.c_flag, 0);
    chk("isr_z", bus.z_flag, 1);
    idle(); bus.shad_restore = 1; bus.i_set = 1; step();
    chk("rest_c", bus.c_flag, 1);
    chk("rest_z", bus.z_flag, 0);
    chk("rest_i", bus.i_flag, 1);

    // masked interrupt
    idle(); bus.i_clr = 1; step();
    idle(); bus.intr = 1; step();
    bus.intr = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("masked", bus.intr_pend, 0);
    end
    bus.i_set = 1; step();
    chk("unmask", bus.intr_pend, 1);

    // collision: new edge on the ack edge
    idle(); bus.intr = 1;
    for (int k = 0; k < D; k++) step();
    bus.intr_ack = 1; step();
    chk("coll_i", bus.i_flag, 0);
    idle(); bus.i_set = 1; step();
    chk("coll_pend", bus.intr_pend, 1);

    // held level gives one event; reset drops pending
    idle(); bus.intr_ack = 1; step();
    idle(); bus.i_set = 1;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("level_once", bus.intr_pend, 0);
    end
    bus.intr = 0; step();
    bus.intr = 1;
    for (int k = 0; k < LAT; k++) step();
    chk("lvl_pend", bus.intr_pend, 1);
    idle(); reset = 1; step();
    chk("rst2_c", bus.c_flag, 0);
    chk("rst2_i", bus.i_flag, 0);
    chk("rst2_pend", bus.intr_pend, 0);
    idle(); bus.i_set = 1;
    for (int k = 0; k < LAT; k++) step();
    chk("rearm", bus.intr_pend, 1);

    // random phase
    for (int n = 0; n < 2000; n++) begin
      idle();
      bus.alu_c = 1'($urandom);
      bus.alu_z = 1'($urandom);
      bus.c_ld = ($urandom_range(3) == 0);
      bus.z_ld = ($urandom_range(3) == 0);
      bus.c_set = ($urandom_range(5) == 0);
      bus.c_clr = ($urandom_range(5) == 0);
      bus.shad_restore = ($urandom_range(9) == 0);
      bus.i_set = ($urandom_range(3) == 0);
      bus.i_clr = ($urandom_range(7) == 0);
      bus.intr_ack = ($urandom_range(7) == 0);
      reset = ($urandom_range(59) == 0);
      if ($urandom_range(3) == 0) bus.intr = ~bus.intr;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
